conf_regs_bank: RTL

Host-side writer for the configuration register array. It accepts a byte stream from the host link (FT245/UART RX) with a valid/ack handshake and assembles 4-byte write frames of address and data. It updates the flat register vector consumed by the configuration wrapper. Address 0x0000 is the request register: writes there produce one-cycle request pulses and are not stored.

---
 rtl/conf_regs_bank_if.sv | 19 +
 rtl/conf_regs_bank.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/conf_regs_bank_if.sv
// Host byte-link handshake: rx_data qualified by rx_rdy, accepted by rx_ack.
// A byte transfers on a rising clock edge where rx_rdy && rx_ack.
interface conf_regs_bank_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ack;

  modport master (
    output rx_data,
    output rx_rdy,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_rdy,
    output rx_ack
  );
endinterface

// File: rtl/conf_regs_bank.sv
// Assembles big-endian 4-byte {addr, data} frames from the host link and writes the register array.
// Register/pulses land 2 cycles after the last byte; rx_ack drops for the single COMMIT cycle only.
module conf_regs_bank #(
  parameter int                              ADDR_WIDTH     = 16,
  parameter int                              DATA_WIDTH     = 16,
  parameter int                              NUM_REGS       = 11,
  parameter logic [DATA_WIDTH*NUM_REGS-1:0] REG_DEFAULTS   = '0,
  parameter logic [15:0]                     TIMEOUT_CYCLES = 16'd1000
) (
  input  logic                           clk,
  input  logic                           rst,
  conf_regs_bank_if.slave                rx,
  output logic [DATA_WIDTH*NUM_REGS-1:0] registers,
  output logic [DATA_WIDTH-1:0]          rqst,
  output logic                           wr_strobe,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic                           addr_err,
  output logic                           frame_err
);

  typedef enum logic [2:0] {
    ADDR_H,
    ADDR_L,
    DATA_H,
    DATA_L,
    COMMIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic                  TO_EN      = (TIMEOUT_CYCLES != 16'd0);
  localparam logic [15:0]           TO_LIMIT   = TIMEOUT_CYCLES - 16'd1;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_WIDTH-1:0]  addr_sr;
  logic [DATA_WIDTH-1:0]  data_sr;
  logic [15:0]            to_cnt;
  logic                   xfer;
  logic                   in_frame;
  logic                   to_hit;
  logic                   addr_is_req;
  logic                   addr_in_range;

  // Register 0 is the request address and never holds state, so only 1..N-1 exist.
  logic [DATA_WIDTH-1:0]  regs [1:NUM_REGS-1];

  assign rx.rx_ack     = (state != COMMIT);
  assign xfer          = rx.rx_rdy && rx.rx_ack;
  assign in_frame      = (state == ADDR_L) || (state == DATA_H) || (state == DATA_L);
  assign to_hit        = TO_EN && in_frame && !xfer && (to_cnt == TO_LIMIT);
  assign addr_is_req   = (addr_sr == '0);
  assign addr_in_range = (addr_sr < NUM_REGS_A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ADDR_H;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ADDR_H: if (xfer) state_nxt = ADDR_L;
      ADDR_L: if (xfer) state_nxt = DATA_H;
      DATA_H: if (xfer) state_nxt = DATA_L;
      DATA_L: if (xfer) state_nxt = COMMIT;
      COMMIT: state_nxt = ADDR_H;
      default: state_nxt = ADDR_H;
    endcase
    if (to_hit) begin
      state_nxt = ADDR_H;
    end
  end

  // Byte capture; a fresh frame always overwrites both shift registers completely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_sr <= '0;
      data_sr <= '0;
    end else if (xfer) begin
      if ((state == ADDR_H) || (state == ADDR_L)) begin
        addr_sr <= {addr_sr[ADDR_WIDTH-9:0], rx.rx_data};
      end else begin
        data_sr <= {data_sr[DATA_WIDTH-9:0], rx.rx_data};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!in_frame || xfer || to_hit || !TO_EN) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 1; h < NUM_REGS; h++) begin
        regs[h] <= REG_DEFAULTS[h*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (state == COMMIT) begin
      for (int h = 1; h < NUM_REGS; h++) begin
        if (addr_sr == ADDR_WIDTH'(h)) begin
          regs[h] <= data_sr;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rqst      <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      addr_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rqst      <= '0;
      wr_strobe <= 1'b0;
      addr_err  <= 1'b0;
      frame_err <= to_hit;
      if (state == COMMIT) begin
        wr_addr <= addr_sr;
        if (addr_in_range) begin
          wr_strobe <= 1'b1;
          if (addr_is_req) begin
            rqst <= data_sr;
          end
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

  assign registers[DATA_WIDTH-1:0] = '0;
  for (genvar h = 1; h < NUM_REGS; h++) begin : g_regs_out
    assign registers[h*DATA_WIDTH +: DATA_WIDTH] = regs[h];
  end

endmodule
